// File: rtl/mc_datapath_md.sv
// Multicycle ARM-subset datapath with a WIDTH-parametrised ALU and an
// iterative shift-add unsigned multiplier that the controller sequences.
module mc_datapath_md #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             reset,
  output logic [WIDTH-1:0] Adr,
  output logic [WIDTH-1:0] WriteData,
  input  logic [WIDTH-1:0] ReadData,
  output logic [WIDTH-1:0] Instr,
  output logic [3:0]       ALUFlags,
  input  logic             PCWrite,
  input  logic             RegWrite,
  input  logic             IRWrite,
  input  logic             AdrSrc,
  input  logic [1:0]       RegSrc,
  input  logic [1:0]       ALUSrcA,
  input  logic [1:0]       ALUSrcB,
  input  logic [1:0]       ResultSrc,
  input  logic [1:0]       ImmSrc,
  input  logic [2:0]       ALUControl,
  input  logic             MulStart,
  output logic             MulBusy,
  output logic             MulDone,
  output logic [WIDTH-1:0] PC
);

  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {MUL_IDLE = 2'd0, MUL_RUN = 2'd1, MUL_DONE = 2'd2} mul_state_t;

  logic [WIDTH-1:0] pc_r, instr_r, data_r, a_r, wd_r, alu_out_r;
  logic [WIDTH-1:0] rf_r [0:14];
  logic [WIDTH-1:0] mcand_r, prod_hi_r, mplier_r, mul_out_r;
  logic [CW-1:0]    count_r;
  mul_state_t       state_r, state_s;

  logic [3:0]       ra1_s, ra2_s, wa_s;
  logic [WIDTH-1:0] rd1_s, rd2_s, src_a_s, src_b_s, ext_imm_s;
  logic [WIDTH-1:0] alu_result_s, result_s;
  logic [WIDTH:0]   sum_s, diff_s, step_s;
  logic             c_s, v_s;

  assign ra1_s = RegSrc[0] ? 4'd15 : instr_r[19:16];
  assign ra2_s = RegSrc[1] ? instr_r[15:12] : instr_r[3:0];
  assign wa_s  = instr_r[15:12];

  // Register-file read ports; R15 has no storage and reflects Result.
  always_comb begin
    rd1_s = '0;
    rd2_s = '0;
    if (ra1_s == 4'd15) begin
      rd1_s = result_s;
    end else begin
      rd1_s = rf_r[ra1_s];
    end
    if (ra2_s == 4'd15) begin
      rd2_s = result_s;
    end else begin
      rd2_s = rf_r[ra2_s];
    end
  end

  // General registers are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (RegWrite && (wa_s != 4'd15)) begin
      rf_r[wa_s] <= result_s;
    end
  end

  // Immediate extension.
  always_comb begin
    ext_imm_s = '0;
    case (ImmSrc)
      2'b00:   ext_imm_s = {{(WIDTH-8){1'b0}}, instr_r[7:0]};
      2'b01:   ext_imm_s = {{(WIDTH-12){1'b0}}, instr_r[11:0]};
      2'b10:   ext_imm_s = {{(WIDTH-26){instr_r[23]}}, instr_r[23:0], 2'b00};
      default: ext_imm_s = '0;
    endcase
  end

  // ALU operand selection.
  always_comb begin
    src_a_s = '0;
    src_b_s = '0;
    case (ALUSrcA)
      2'b00:   src_a_s = a_r;
      2'b01:   src_a_s = pc_r;
      2'b10:   src_a_s = alu_out_r;
      default: src_a_s = '0;
    endcase
    case (ALUSrcB)
      2'b00:   src_b_s = wd_r;
      2'b01:   src_b_s = ext_imm_s;
      2'b10:   src_b_s = WIDTH'(4);
      default: src_b_s = WIDTH'(8);
    endcase
  end

  assign sum_s  = {1'b0, src_a_s} + {1'b0, src_b_s};
  assign diff_s = {1'b0, src_a_s} + {1'b0, ~src_b_s} + (WIDTH+1)'(1);

  // ALU result and carry/overflow; carry on SUB is NOT borrow.
  always_comb begin
    alu_result_s = '0;
    c_s = 1'b0;
    v_s = 1'b0;
    case (ALUControl)
      3'b000: begin
        alu_result_s = sum_s[WIDTH-1:0];
        c_s = sum_s[WIDTH];
        v_s = (src_a_s[WIDTH-1] == src_b_s[WIDTH-1]) && (sum_s[WIDTH-1] != src_a_s[WIDTH-1]);
      end
      3'b001: begin
        alu_result_s = diff_s[WIDTH-1:0];
        c_s = diff_s[WIDTH];
        v_s = (src_a_s[WIDTH-1] != src_b_s[WIDTH-1]) && (diff_s[WIDTH-1] != src_a_s[WIDTH-1]);
      end
      3'b010:  alu_result_s = src_a_s & src_b_s;
      3'b011:  alu_result_s = src_a_s | src_b_s;
      3'b100:  alu_result_s = src_a_s ^ src_b_s;
      3'b101:  alu_result_s = src_b_s;
      3'b110:  alu_result_s = src_a_s << src_b_s[SHW-1:0];
      default: alu_result_s = '0;
    endcase
  end

  assign ALUFlags = {alu_result_s[WIDTH-1], (alu_result_s == '0), c_s, v_s};

  // Result bus selection.
  always_comb begin
    result_s = '0;
    case (ResultSrc)
      2'b00:   result_s = alu_out_r;
      2'b01:   result_s = data_r;
      2'b10:   result_s = alu_result_s;
      default: result_s = mul_out_r;
    endcase
  end

  // Memory address; pinned to the reset vector while reset is held.
  always_comb begin
    Adr = '0;
    if (!reset) begin
      Adr = RESET_PC;
    end else if (AdrSrc) begin
      Adr = result_s;
    end else begin
      Adr = pc_r;
    end
  end

  // Architectural and pipeline-boundary registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_r      <= RESET_PC;
      instr_r   <= '0;
      data_r    <= '0;
      a_r       <= '0;
      wd_r      <= '0;
      alu_out_r <= '0;
    end else begin
      if (PCWrite) begin
        pc_r <= result_s;
      end
      if (IRWrite) begin
        instr_r <= ReadData;
      end
      data_r    <= ReadData;
      a_r       <= rd1_s;
      wd_r      <= rd2_s;
      alu_out_r <= alu_result_s;
    end
  end

  // Multiplier sequencing; starts are only honoured from IDLE.
  always_comb begin
    state_s = state_r;
    case (state_r)
      MUL_IDLE: state_s = MulStart ? MUL_RUN : MUL_IDLE;
      MUL_RUN:  state_s = (count_r == CW'(1)) ? MUL_DONE : MUL_RUN;
      MUL_DONE: state_s = MUL_IDLE;
      default:  state_s = MUL_IDLE;
    endcase
  end

  // Multiplier state register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= MUL_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // One shift-add step: {carry, prod_hi} is the partial sum before shifting.
  assign step_s = {1'b0, prod_hi_r} + (mplier_r[0] ? {1'b0, mcand_r} : (WIDTH+1)'(0));

  // Multiplier datapath; the low product half lives in the multiplier register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      mcand_r   <= '0;
      prod_hi_r <= '0;
      mplier_r  <= '0;
      count_r   <= '0;
      mul_out_r <= '0;
    end else begin
      case (state_r)
        MUL_IDLE: begin
          if (MulStart) begin
            mcand_r   <= a_r;
            mplier_r  <= wd_r;
            prod_hi_r <= '0;
            count_r   <= CW'(WIDTH);
          end
        end
        MUL_RUN: begin
          prod_hi_r <= step_s[WIDTH:1];
          mplier_r  <= {step_s[0], mplier_r[WIDTH-1:1]};
          count_r   <= count_r - CW'(1);
          if (count_r == CW'(1)) begin
            mul_out_r <= {step_s[0], mplier_r[WIDTH-1:1]};
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign MulBusy   = (state_r == MUL_RUN);
  assign MulDone   = (state_r == MUL_DONE);
  assign PC        = pc_r;
  assign Instr     = instr_r;
  assign WriteData = wd_r;

endmodule

// File: tb/tb_mc_datapath_md.sv
// Directed-plus-random bench for mc_datapath_md (WIDTH=32, RESET_PC=0x100),
// checked against arithmetic reference models of the ALU, extender and multiplier.
module tb_mc_datapath_md;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Adr, WriteData, ReadData, Instr, PC;
  logic [3:0]  ALUFlags;
  logic        PCWrite, RegWrite, IRWrite, AdrSrc;
  logic [1:0]  RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc;
  logic [2:0]  ALUControl;
  logic        MulStart, MulBusy, MulDone;

  int errors = 0;
  int checks = 0;

  mc_datapath_md #(.WIDTH(32), .RESET_PC(32'h0000_0100)) dut (
    .clk(clk), .reset(reset), .Adr(Adr), .WriteData(WriteData), .ReadData(ReadData),
    .Instr(Instr), .ALUFlags(ALUFlags), .PCWrite(PCWrite), .RegWrite(RegWrite),
    .IRWrite(IRWrite), .AdrSrc(AdrSrc), .RegSrc(RegSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .ALUControl(ALUControl),
    .MulStart(MulStart), .MulBusy(MulBusy), .MulDone(MulDone), .PC(PC)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk_instr(input logic [3:0] rn, input logic [3:0] rd, input logic [3:0] rm);
    return {12'h000, rn, rd, 8'h00, rm};
  endfunction

  // Reference ALU from plain integer arithmetic.
  function automatic void alu_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] r, output logic [3:0] f);
    longint sa, sb, full;
    logic [63:0] wide;
    logic c, v;
    sa = $signed(a);
    sb = $signed(b);
    c = 1'b0;
    v = 1'b0;
    r = 32'h0;
    case (op)
      3'd0: begin
        wide = {32'h0, a} + {32'h0, b};
        r = wide[31:0];
        c = wide[32];
        full = sa + sb;
        v = (full > 64'sd2147483647) || (full < -64'sd2147483648);
      end
      3'd1: begin
        r = a - b;
        c = (a >= b);
        full = sa - sb;
        v = (full > 64'sd2147483647) || (full < -64'sd2147483648);
      end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = b;
      3'd6: r = a << b[4:0];
      default: r = 32'h0;
    endcase
    f = {r[31], (r == 32'h0), c, v};
  endfunction

  function automatic logic [31:0] ext_model(input logic [1:0] sel, input logic [31:0] w);
    logic signed [31:0] t;
    t = $signed({w[23:0], 8'h00}) >>> 6;
    case (sel)
      2'd0: return {24'h0, w[7:0]};
      2'd1: return {20'h0, w[11:0]};
      2'd2: return t;
      default: return 32'h0;
    endcase
  endfunction

  task automatic set_instr(input logic [31:0] w);
    ReadData = w;
    IRWrite = 1'b1;
    tick();
    IRWrite = 1'b0;
  endtask

  // Register writes route through the Data register (ResultSrc=1).
  task automatic write_reg(input logic [3:0] rd, input logic [31:0] val);
    set_instr(mk_instr(4'd1, rd, 4'd2));
    ReadData = val;
    tick();
    ResultSrc = 2'd1;
    RegWrite = 1'b1;
    tick();
    RegWrite = 1'b0;
  endtask

  task automatic load_ab(input logic [31:0] a, input logic [31:0] b);
    RegSrc = 2'b00;
    write_reg(4'd1, a);
    write_reg(4'd2, b);
    tick();
  endtask

  // Route A unchanged onto Adr: A + 0.
  task automatic observe_a(input string tag, input logic [31:0] exp);
    ALUSrcA = 2'd0; ALUSrcB = 2'd1; ImmSrc = 2'd3; ALUControl = 3'd0;
    ResultSrc = 2'd2; AdrSrc = 1'b1; RegSrc = 2'b00;
    #1;
    check(tag, Adr, exp);
  endtask

  task automatic alu_case(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic [3:0] f;
    load_ab(a, b);
    ALUSrcA = 2'd0; ALUSrcB = 2'd0; ALUControl = op; ResultSrc = 2'd2; AdrSrc = 1'b1;
    #1;
    alu_model(op, a, b, r, f);
    check({tag, "_wd"}, WriteData, b);
    check({tag, "_res"}, Adr, r);
    check({tag, "_flags"}, ALUFlags, f);
  endtask

  task automatic mul_check(input string tag, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] prod;
    int cyc;
    logic busy_bad;
    prod = {32'h0, a} * {32'h0, b};
    load_ab(a, b);
    MulStart = 1'b1;
    tick();
    MulStart = 1'b0;
    cyc = 1;
    busy_bad = 1'b0;
    write_reg(4'd1, ~a);
    write_reg(4'd2, b ^ 32'h0000_FFFF);
    tick();
    cyc += 7;
    ResultSrc = 2'd3; AdrSrc = 1'b1;
    while (MulDone !== 1'b1 && cyc < 200) begin
      if (MulBusy !== 1'b1) busy_bad = 1'b1;
      tick();
      cyc++;
    end
    check({tag, "_latency"}, cyc, 33);
    check({tag, "_busy"}, busy_bad, 1'b0);
    check({tag, "_done_not_busy"}, MulBusy, 1'b0);
    check({tag, "_product"}, Adr, prod[31:0]);
    tick();
    check({tag, "_done_pulse"}, MulDone, 1'b0);
    check({tag, "_hold"}, Adr, prod[31:0]);
  endtask

  initial begin
    int cyc;
    logic seen_done;
    logic [31:0] w;
    logic [2:0] op;

    reset = 1'b0; ReadData = 32'h0; PCWrite = 1'b0; RegWrite = 1'b0; IRWrite = 1'b0;
    AdrSrc = 1'b1; RegSrc = 2'b00; ALUSrcA = 2'd0; ALUSrcB = 2'd0; ResultSrc = 2'd2;
    ImmSrc = 2'd0; ALUControl = 3'd0; MulStart = 1'b0;
    tick();
    check("adr_in_reset", Adr, 32'h100);
    tick();
    reset = 1'b1; AdrSrc = 1'b0;
    #1;
    check("reset_pc", PC, 32'h100);
    check("reset_adr", Adr, 32'h100);
    check("reset_instr", Instr, 32'h0);
    check("reset_busy", MulBusy, 1'b0);
    check("reset_done", MulDone, 1'b0);
    check("reset_wd", WriteData, 32'h0);
    check("reset_flags", ALUFlags, 4'b0100);
    AdrSrc = 1'b1; ResultSrc = 2'd0;
    #1;
    check("reset_aluout", Adr, 32'h0);
    ResultSrc = 2'd3;
    #1;
    check("reset_mulout", Adr, 32'h0);

    // Fetch.
    AdrSrc = 1'b0; ReadData = 32'hE281_1005; IRWrite = 1'b1; PCWrite = 1'b1;
    ALUSrcA = 2'd1; ALUSrcB = 2'd2; ResultSrc = 2'd2; ALUControl = 3'd0;
    tick();
    IRWrite = 1'b0; PCWrite = 1'b0;
    check("fetch_instr", Instr, 32'hE281_1005);
    check("fetch_pc", PC, 32'h104);

    // Decode: R15 read yields Result = PC+4 (= fetch PC + 8).
    RegSrc = 2'b01; AdrSrc = 1'b1;
    #1;
    check("decode_result", Adr, 32'h108);
    tick();
    observe_a("r15_read_a", 32'h108);

    // ALU flag corner cases, then random operations.
    alu_case("sub_eq", 3'd1, 32'd5, 32'd5);
    check("sub_eq_const", ALUFlags, 4'b0110);
    alu_case("add_ovf", 3'd0, 32'h7FFF_FFFF, 32'h1);
    check("add_ovf_const", ALUFlags, 4'b1001);
    alu_case("lsl31", 3'd6, 32'h1, 32'd31);
    check("lsl31_const", Adr, 32'h8000_0000);
    alu_case("add_carry", 3'd0, 32'hFFFF_FFFF, 32'h2);
    alu_case("sub_borrow", 3'd1, 32'h3, 32'h8000_0000);
    for (int i = 0; i < 16; i++) begin
      op = 3'($urandom_range(7, 0));
      alu_case("alu_rand", op, $urandom, $urandom);
    end

    // Immediate extension and constant sources.
    for (int i = 0; i < 4; i++) begin
      w = $urandom;
      if (i == 2) w[23] = 1'b1;
      set_instr(w);
      ALUSrcB = 2'd1; ImmSrc = 2'(i); ALUControl = 3'd5; ResultSrc = 2'd2; AdrSrc = 1'b1;
      #1;
      check("ext_imm", Adr, ext_model(2'(i), w));
    end
    ALUSrcA = 2'd3; ALUSrcB = 2'd3; ALUControl = 3'd0;
    #1;
    check("zero_plus_8", Adr, 32'h8);

    // R15 writes are dropped; neighbours keep their contents.
    write_reg(4'd7, 32'h0000_0077);
    write_reg(4'd15, 32'h0000_DEAD);
    set_instr(mk_instr(4'd7, 4'd0, 4'd2));
    tick();
    observe_a("r7_intact", 32'h77);
    RegSrc = 2'b01; ResultSrc = 2'd1; ReadData = 32'h0000_1234;
    tick();
    tick();
    observe_a("r15_is_result", 32'h1234);

    // Multiplies: directed then random, operands disturbed during RUN.
    mul_check("mul_dir", 32'hFFFF_FFFF, 32'h2);
    for (int i = 0; i < 3; i++) begin
      mul_check("mul_rand", $urandom, $urandom);
    end

    // MulStart held high: ignored through RUN/DONE, re-accepted afterwards.
    load_ab(32'd3, 32'd5);
    ResultSrc = 2'd3; AdrSrc = 1'b1;
    MulStart = 1'b1;
    tick();
    cyc = 1;
    while (MulDone !== 1'b1 && cyc < 200) begin
      tick();
      cyc++;
    end
    check("held_latency", cyc, 33);
    check("held_product", Adr, 32'd15);
    tick();
    check("held_idle_busy", MulBusy, 1'b0);
    check("held_idle_done", MulDone, 1'b0);
    tick();
    check("held_reaccept", MulBusy, 1'b1);
    MulStart = 1'b0;
    cyc = 1;
    while (MulDone !== 1'b1 && cyc < 200) begin
      tick();
      cyc++;
    end
    check("held_second_latency", cyc, 33);
    tick();

    // Reset during RUN aborts and clears the product.
    load_ab(32'd9, 32'd7);
    MulStart = 1'b1;
    tick();
    MulStart = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    check("abort_busy_before", MulBusy, 1'b1);
    reset = 1'b0;
    tick();
    ResultSrc = 2'd3; AdrSrc = 1'b1;
    #1;
    check("abort_adr_in_reset", Adr, 32'h100);
    reset = 1'b1;
    #1;
    check("abort_busy", MulBusy, 1'b0);
    check("abort_done", MulDone, 1'b0);
    check("abort_mulout", Adr, 32'h0);
    check("abort_pc", PC, 32'h100);
    check("abort_wd", WriteData, 32'h0);
    seen_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (MulDone !== 1'b0) seen_done = 1'b1;
    end
    check("abort_no_done", seen_done, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
